// File: rtl/pipeline_3_memory.sv
// Memory-access / writeback stage: performs loads and stores over a req/ready
// handshake, stalls upstream while busy, and drives the register-file write port.
module pipeline_3_memory #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [21:0]       control_in,
    input  logic [15:0]       result_in,
    input  logic [15:0]       data_Rd_in,
    input  logic [2:0]        num_Rd_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [15:0]       mem_rdata,
    output logic              wb_en,
    output logic [2:0]        wb_num,
    output logic [15:0]       wb_data,
    output logic              stage_fwd_valid,
    output logic [2:0]        stage_fwd_num,
    output logic [15:0]       stage_fwd_data,
    output logic              mem_err
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;

    logic [21:0] r_ctrl;
    logic [15:0] r_result;
    logic [15:0] r_data;
    logic [2:0]  r_rd;

    logic        r_wb_en;
    logic [2:0]  r_wb_num;
    logic [15:0] r_wb_data;
    logic        r_err;

    logic        w_is_mem;
    logic        w_stall;
    logic        w_req;
    logic        w_commit;
    logic        w_abort;
    logic        w_unused_ctrl;

    assign w_is_mem      = r_ctrl[1] | r_ctrl[2];
    assign w_unused_ctrl = ^r_ctrl[21:3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Ready is checked before the timeout, so a ready arriving on the last
    // permitted cycle still completes the access.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_req       = 1'b0;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_is_mem) begin
                    w_stall     = 1'b1;
                    w_state_nxt = REQ;
                    w_cnt_nxt   = '0;
                end else begin
                    w_commit = 1'b1;
                end
            end
            REQ: begin
                w_req   = 1'b1;
                w_stall = ~mem_ready;
                if (mem_ready) begin
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl    <= '0;
            r_result  <= '0;
            r_data    <= '0;
            r_rd      <= '0;
            r_wb_en   <= 1'b0;
            r_wb_num  <= '0;
            r_wb_data <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_abort) begin
                r_ctrl   <= '0;
                r_result <= '0;
                r_data   <= '0;
                r_rd     <= '0;
            end else if (!w_stall) begin
                r_ctrl   <= control_in;
                r_result <= result_in;
                r_data   <= data_Rd_in;
                r_rd     <= num_Rd_in;
            end

            // An IDLE commit never has mem_read set, so the mux only selects
            // read data for completed loads.
            if (w_commit) begin
                r_wb_en   <= r_ctrl[0];
                r_wb_num  <= r_rd;
                r_wb_data <= r_ctrl[1] ? mem_rdata : r_result;
            end else if (w_abort) begin
                r_wb_en <= 1'b0;
                r_err   <= 1'b1;
            end
        end
    end

    assign stall_out       = w_stall;
    assign mem_req         = w_req;
    assign mem_we          = w_req & r_ctrl[2] & ~r_ctrl[1];
    assign mem_addr        = r_result[ADDR_W-1:0];
    assign mem_wdata       = r_data;
    assign wb_en           = r_wb_en;
    assign wb_num          = r_wb_num;
    assign wb_data         = r_wb_data;
    assign stage_fwd_valid = r_ctrl[0] & ~r_ctrl[1];
    assign stage_fwd_num   = r_rd;
    assign stage_fwd_data  = r_result;
    assign mem_err         = r_err;

endmodule

// File: tb/tb_pipeline_3_memory.sv
// Randomized bench for pipeline_3_memory: a per-instruction schedule (occupancy
// and commit cycle from the latency rules) predicts every output cycle by cycle.
module tb_pipeline_3_memory;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 15;

    // d = number of not-ready REQ cycles before ready; d >= TIMEOUT never completes
    typedef struct {
        logic [21:0] ctrl;
        logic [15:0] res;
        logic [15:0] sd;
        logic [2:0]  rd;
        int unsigned d;
        logic [15:0] rdata;
    } instr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [21:0]       control_in = '0;
    logic [15:0]       result_in = '0;
    logic [15:0]       data_Rd_in = '0;
    logic [2:0]        num_Rd_in = '0;
    logic              stall_out;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ready = 1'b0;
    logic [15:0]       mem_rdata = '0;
    logic              wb_en;
    logic [2:0]        wb_num;
    logic [15:0]       wb_data;
    logic              stage_fwd_valid;
    logic [2:0]        stage_fwd_num;
    logic [15:0]       stage_fwd_data;
    logic              mem_err;

    int          n_vec = 0;
    int          n_err = 0;
    logic        exp_en;
    logic [2:0]  exp_num;
    logic [15:0] exp_data;
    logic        exp_err;
    instr_t      prog[$];

    pipeline_3_memory #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .control_in     (control_in),
        .result_in      (result_in),
        .data_Rd_in     (data_Rd_in),
        .num_Rd_in      (num_Rd_in),
        .stall_out      (stall_out),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .wb_en          (wb_en),
        .wb_num         (wb_num),
        .wb_data        (wb_data),
        .stage_fwd_valid(stage_fwd_valid),
        .stage_fwd_num  (stage_fwd_num),
        .stage_fwd_data (stage_fwd_data),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    function automatic instr_t mk(input logic [21:0] c, input logic [15:0] r, input logic [15:0] s,
                                  input logic [2:0] rd, input int unsigned d, input logic [15:0] rdat);
        instr_t t;
        t.ctrl  = c;
        t.res   = r;
        t.sd    = s;
        t.rd    = rd;
        t.d     = d;
        t.rdata = rdat;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic drive(input instr_t n, input logic rdy, input logic [15:0] rdat);
        control_in = n.ctrl;
        result_in  = n.res;
        data_Rd_in = n.sd;
        num_Rd_in  = n.rd;
        mem_ready  = rdy;
        mem_rdata  = rdat;
    endtask

    // s = instruction occupying the stage, o = cycles it has been there
    task automatic check_outputs(input instr_t s, input int unsigned o, input logic rdy);
        logic ism;
        logic req;
        ism = s.ctrl[1] | s.ctrl[2];
        req = ism && (o >= 1);
        chk("stall_out", 16'(stall_out), ism ? ((o == 0) ? 16'd1 : 16'(!rdy)) : 16'd0);
        chk("mem_req", 16'(mem_req), 16'(req));
        if (req) begin
            chk("mem_we", 16'(mem_we), 16'(s.ctrl[2] & ~s.ctrl[1]));
            chk("mem_addr", 16'(mem_addr), 16'(s.res[ADDR_W-1:0]));
            chk("mem_wdata", mem_wdata, s.sd);
        end
        chk("fwd_valid", 16'(stage_fwd_valid), 16'(s.ctrl[0] & ~s.ctrl[1]));
        chk("fwd_num", 16'(stage_fwd_num), 16'(s.rd));
        chk("fwd_data", stage_fwd_data, s.res);
        chk("wb_en", 16'(wb_en), 16'(exp_en));
        chk("wb_num", 16'(wb_num), 16'(exp_num));
        chk("wb_data", wb_data, exp_data);
        chk("mem_err", 16'(mem_err), 16'(exp_err));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded time limit (%0d miscompares so far)", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t      bub;
        instr_t      cur;
        instr_t      nxt;
        logic        ism;
        logic        abort;
        logic        rdy;
        logic [15:0] rdv;
        int unsigned dur;
        logic [21:0] c;
        int unsigned cls;
        int unsigned r;

        bub = mk(22'h0, 16'h0, 16'h0, 3'd0, 0, 16'h0);

        // directed scenarios first, then random traffic
        prog.push_back(mk(22'h000001, 16'h1234, 16'h0000, 3'd3, 0, 16'h0000));
        prog.push_back(mk(22'h000003, 16'h0042, 16'h0000, 3'd5, 0, 16'hBEEF));
        prog.push_back(mk(22'h000004, 16'h0010, 16'h00AA, 3'd2, 3, 16'h0000));
        prog.push_back(mk(22'h000003, 16'h0077, 16'h0000, 3'd4, 99, 16'h0000));
        prog.push_back(mk(22'h000001, 16'h7777, 16'h0000, 3'd1, 0, 16'h0000));
        prog.push_back(mk(22'h000003, 16'h0020, 16'h0000, 3'd6, 2, 16'hCAFE));
        prog.push_back(mk(22'h000001, 16'h5151, 16'h0000, 3'd7, 0, 16'h0000));
        prog.push_back(mk(22'h000003, 16'h00F0, 16'h0000, 3'd2, TIMEOUT - 1, 16'h1357));
        prog.push_back(mk(22'h000003, 16'h00F1, 16'h0000, 3'd3, TIMEOUT, 16'h2468));
        prog.push_back(mk(22'h3FFFF7, 16'hA5C3, 16'h3C3C, 3'd4, 1, 16'h9ABC));
        for (int i = 0; i < 50; i++) begin
            c   = 22'($urandom);
            cls = $urandom_range(0, 5);
            c[2:1] = (cls == 2) ? 2'b01 : (cls == 3) ? 2'b10 : (cls == 4) ? 2'b11 : 2'b00;
            r = $urandom_range(0, 9);
            prog.push_back(mk(c, 16'($urandom), 16'($urandom), 3'($urandom), 
                              (r < 7) ? $urandom_range(0, 3) : (r == 7) ? TIMEOUT - 1 :
                              (r == 8) ? TIMEOUT : $urandom_range(0, 20),
                              16'($urandom)));
        end

        exp_en   = 1'b0;
        exp_num  = '0;
        exp_data = '0;
        exp_err  = 1'b0;

        drive(bub, 1'b1, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check_outputs(bub, 0, 1'b1);
        rst = 1'b0;

        drive(prog[0], 1'($urandom_range(0, 1)), 16'($urandom));
        #1;
        check_outputs(bub, 0, mem_ready);
        @(posedge clk);
        #1;

        for (int k = 0; k < prog.size(); k++) begin
            cur   = prog[k];
            nxt   = (k + 1 < prog.size()) ? prog[k + 1] : bub;
            ism   = cur.ctrl[1] | cur.ctrl[2];
            abort = ism && (cur.d >= TIMEOUT);
            dur   = !ism ? 1 : abort ? TIMEOUT + 1 : cur.d + 2;
            for (int unsigned o = 0; o < dur; o++) begin
                if (ism && o >= 1) rdy = (o == cur.d + 1);
                else rdy = 1'($urandom_range(0, 1));
                rdv = (ism && o >= 1 && rdy) ? cur.rdata : 16'($urandom);
                drive(nxt, rdy, rdv);
                #1;
                check_outputs(cur, o, rdy);
                @(posedge clk);
                #1;
            end
            if (abort) begin
                exp_en  = 1'b0;
                exp_err = 1'b1;
                // the aborted slot leaves a bubble that completes on the next edge
                drive(nxt, 1'($urandom_range(0, 1)), 16'($urandom));
                #1;
                check_outputs(bub, 0, mem_ready);
                @(posedge clk);
                #1;
                exp_num  = '0;
                exp_data = '0;
            end else begin
                exp_en   = cur.ctrl[0];
                exp_num  = cur.rd;
                exp_data = cur.ctrl[1] ? cur.rdata : cur.res;
            end
        end

        for (int i = 0; i < 2; i++) begin
            drive(bub, 1'($urandom_range(0, 1)), 16'($urandom));
            #1;
            check_outputs(bub, 0, mem_ready);
            @(posedge clk);
            #1;
            exp_en   = 1'b0;
            exp_num  = '0;
            exp_data = '0;
        end

        // reset during REQ while memory signals ready in the same cycle
        cur = mk(22'h000001, 16'h5A5A, 16'h0000, 3'd3, 0, 16'h0000);
        nxt = mk(22'h000003, 16'h0033, 16'h0000, 3'd6, 0, 16'hBEEF);
        drive(cur, 1'b0, 16'h0);
        #1;
        check_outputs(bub, 0, 1'b0);
        @(posedge clk);
        #1;
        drive(nxt, 1'b0, 16'h0);
        #1;
        check_outputs(cur, 0, 1'b0);
        @(posedge clk);
        #1;
        exp_en   = 1'b1;
        exp_num  = 3'd3;
        exp_data = 16'h5A5A;
        drive(nxt, 1'b1, 16'h0);
        #1;
        check_outputs(nxt, 0, 1'b1);
        @(posedge clk);
        #1;
        drive(bub, 1'b1, 16'hBEEF);
        rst = 1'b1;
        #1;
        check_outputs(nxt, 1, 1'b1);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_en   = 1'b0;
        exp_num  = '0;
        exp_data = '0;
        exp_err  = 1'b0;
        drive(bub, 1'b0, 16'h0);
        #1;
        check_outputs(bub, 0, 1'b0);
        @(posedge clk);
        #1;
        check_outputs(bub, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
